sram_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one SRAM-like bus (req / addr_ok / data_ok handshake) between four masters, e.g. instruction fetch, data access, and two auxiliary ports. It sequences one transaction at a time, latches the winner, and drives the 2-bit select that steers the shared 4:1 address/write-data mux toward the slave. It sits between the CPU-side SRAM interfaces and the single memory port.

---
 rtl/sram_arbiter4.sv | 134 +++++++++++++
 tb/tb_sram_arbiter4.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter4.sv
// Four-master round-robin arbiter for a single req/addr_ok/data_ok SRAM-like bus.
// Runs one transaction at a time and steers the shared address/write-data mux with a registered select.
module sram_arbiter4 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [3:0]      m_req,
    input  logic [3:0]      m_wr,
    input  logic [4*AW-1:0] m_addr,
    input  logic [4*DW-1:0] m_wdata,
    output logic [3:0]      m_addr_ok,
    output logic [3:0]      m_data_ok,
    output logic [DW-1:0]   m_rdata,
    output logic            s_req,
    output logic            s_wr,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    input  logic            s_addr_ok,
    input  logic            s_data_ok,
    input  logic [DW-1:0]   s_rdata,
    output logic [1:0]      sel,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [1:0]    sel_reg;
    logic [1:0]    sel_next;
    logic [1:0]    ptr_reg;
    logic [1:0]    ptr_next;

    logic [1:0]    cand_idx [4];
    logic [3:0]    cand_req;
    logic [AW-1:0] addr_arr [4];
    logic [DW-1:0] wdata_arr [4];
    logic [1:0]    winner;
    logic          any_req;
    logic [3:0]    grant_onehot;

    // Candidate k is the requester k+1 positions after the last grant, so
    // the lowest set candidate is the round-robin winner.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            assign addr_arr[gi]  = m_addr[gi*AW +: AW];
            assign wdata_arr[gi] = m_wdata[gi*DW +: DW];
            assign cand_idx[gi]  = ptr_reg + 2'(gi + 1);
            assign cand_req[gi]  = m_req[cand_idx[gi]];
        end
    endgenerate

    assign any_req = |m_req;

    always_comb begin
        winner = cand_idx[3];
        for (int k = 3; k >= 0; k--) begin
            if (cand_req[k]) begin
                winner = cand_idx[k];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            ptr_reg   <= 2'd3;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = ADDR;
                    sel_next   = winner;
                    ptr_next   = winner;
                end
            end
            ADDR: begin
                // A master dropping its request here does not cancel the slave access.
                if (s_addr_ok) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (s_data_ok) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign grant_onehot = 4'b0001 << sel_reg;

    always_comb begin
        s_req     = (state_reg == ADDR);
        s_wr      = m_wr[sel_reg];
        s_addr    = addr_arr[sel_reg];
        s_wdata   = wdata_arr[sel_reg];
        m_addr_ok = 4'b0000;
        m_data_ok = 4'b0000;
        // Slave handshakes outside their own phase are dropped, never forwarded.
        if (state_reg == ADDR && s_addr_ok) begin
            m_addr_ok = grant_onehot;
        end
        if (state_reg == DATA && s_data_ok) begin
            m_data_ok = grant_onehot;
        end
    end

    assign m_rdata = s_rdata;
    assign sel     = sel_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_sram_arbiter4.sv
// Bench for sram_arbiter4: directed scenarios plus a randomized run against a
// transaction-level model of the round-robin bus sharing.
module tb_sram_arbiter4;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            resetn;
    logic [3:0]      m_req;
    logic [3:0]      m_wr;
    logic [4*AW-1:0] m_addr;
    logic [4*DW-1:0] m_wdata;
    logic [3:0]      m_addr_ok;
    logic [3:0]      m_data_ok;
    logic [DW-1:0]   m_rdata;
    logic            s_req;
    logic            s_wr;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_addr_ok;
    logic            s_data_ok;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      sel;
    logic            busy;

    int tests = 0;
    int fails = 0;

    sram_arbiter4 #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_wr[i]             = wr;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        m_req     = '0;
        m_wr      = '0;
        m_addr    = '0;
        m_wdata   = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = '0;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        m_req     = '0;
        m_wr      = '0;
        m_addr    = '0;
        m_wdata   = '0;
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;
        s_rdata   = '0;
        tick();
        #1;
        tests++;
        if (sel !== 2'd0) begin fails++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        tests++;
        if (busy !== 1'b0 || s_req !== 1'b0) begin fails++; $display("FAIL reset_busy_sreq: got busy=%b s_req=%b expected 0 0", busy, s_req); end
        tests++;
        if (m_addr_ok !== 4'b0 || m_data_ok !== 4'b0) begin fails++; $display("FAIL reset_oks: got addr_ok=%b data_ok=%b expected 0000 0000", m_addr_ok, m_data_ok); end
        tick();
        resetn    = 1'b1;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
    endtask

    task automatic test_single_read();
        logic [AW-1:0] a2;
        a2 = $urandom;
        do_reset();
        set_master(2, 1'b0, a2, 32'h0);
        m_req[2] = 1'b1;
        #1;
        tests++;
        if (s_req !== 1'b0) begin fails++; $display("FAIL read_no_early_sreq: got %b expected 0", s_req); end
        tick();
        #1;
        tests++;
        if (s_req !== 1'b1 || sel !== 2'd2) begin fails++; $display("FAIL read_grant: got s_req=%b sel=%0d expected 1 2", s_req, sel); end
        tests++;
        if (s_addr !== a2 || s_wr !== 1'b0) begin fails++; $display("FAIL read_addr: got %h wr=%b expected %h 0", s_addr, s_wr, a2); end
        tests++;
        if (m_addr_ok !== 4'b0000) begin fails++; $display("FAIL read_early_aok: got %b expected 0000", m_addr_ok); end
        tick();
        s_addr_ok = 1'b1;
        #1;
        tests++;
        if (m_addr_ok !== 4'b0100) begin fails++; $display("FAIL read_aok: got %b expected 0100", m_addr_ok); end
        tick();
        m_req     = '0;
        s_addr_ok = 1'b0;
        #1;
        tests++;
        if (s_req !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL read_data_phase: got s_req=%b busy=%b expected 0 1", s_req, busy); end
        tick();
        s_data_ok = 1'b1;
        s_rdata   = 32'hDEADBEEF;
        #1;
        tests++;
        if (m_data_ok !== 4'b0100) begin fails++; $display("FAIL read_dok: got %b expected 0100", m_data_ok); end
        tests++;
        if (m_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL read_rdata: got %h expected deadbeef", m_rdata); end
        tick();
        s_data_ok = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || sel !== 2'd2) begin fails++; $display("FAIL read_back_idle: got busy=%b sel=%0d expected 0 2", busy, sel); end
        $display("[TB] read req2 addr=%h rdata=%h", a2, m_rdata);
    endtask

    task automatic test_all_four();
        int grants[$];
        int gcyc[$];
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) set_master(i, 1'b0, 32'h100 * (i + 1), 32'h0);
        m_req     = 4'b1111;
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;
        for (int c = 0; c < 18; c++) begin
            tick();
            #1;
            if (s_req) begin
                grants.push_back(int'(sel));
                gcyc.push_back(c);
                tests++;
                if (m_addr_ok !== (4'b0001 << sel)) begin fails++; $display("FAIL all4_aok: got %b for sel %0d", m_addr_ok, sel); end
            end
        end
        tests++;
        if (grants.size() != 6) begin fails++; $display("FAIL all4_count: got %0d grants expected 6", grants.size()); end
        for (int k = 0; k < 6; k++) begin
            if (k < grants.size()) begin
                tests++;
                if (grants[k] != exp_order[k]) begin fails++; $display("FAIL all4_order[%0d]: got %0d expected %0d", k, grants[k], exp_order[k]); end
                if (k > 0) begin
                    tests++;
                    if (gcyc[k] - gcyc[k-1] != 3) begin fails++; $display("FAIL all4_period[%0d]: got %0d expected 3", k, gcyc[k] - gcyc[k-1]); end
                end
                $display("[TB] all4 grant %0d -> requester %0d", k, grants[k]);
            end
        end
    endtask

    task automatic test_rr_13();
        int grants[$];
        int exp_order[5] = '{1, 3, 0, 1, 3};
        do_reset();
        for (int i = 0; i < 4; i++) set_master(i, 1'b1, 32'h2000 + i, 32'h0);
        m_req     = 4'b0010;
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;
        for (int c = 0; c < 20 && grants.size() < 5; c++) begin
            tick();
            #1;
            if (s_req) begin
                grants.push_back(int'(sel));
                if (grants.size() == 1) m_req = 4'b1010;
                if (grants.size() == 2) m_req = 4'b1011;
            end
        end
        tests++;
        if (grants.size() != 5) begin fails++; $display("FAIL rr13_count: got %0d grants expected 5", grants.size()); end
        for (int k = 0; k < grants.size(); k++) begin
            tests++;
            if (grants[k] != exp_order[k]) begin fails++; $display("FAIL rr13_order[%0d]: got %0d expected %0d", k, grants[k], exp_order[k]); end
            $display("[TB] rr13 grant %0d -> requester %0d", k, grants[k]);
        end
    endtask

    task automatic test_write_stall();
        do_reset();
        set_master(0, 1'b1, 32'h1000, 32'h12345678);
        m_req[0] = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            s_addr_ok = (c == 4);
            #1;
            tests++;
            if (s_req !== 1'b1 || s_wr !== 1'b1 || s_addr !== 32'h1000 || s_wdata !== 32'h12345678) begin
                fails++;
                $display("FAIL wr_stable[%0d]: got req=%b wr=%b addr=%h wdata=%h expected 1 1 00001000 12345678", c, s_req, s_wr, s_addr, s_wdata);
            end
            tests++;
            if (m_addr_ok !== ((c == 4) ? 4'b0001 : 4'b0000)) begin fails++; $display("FAIL wr_aok[%0d]: got %b", c, m_addr_ok); end
            tick();
        end
        m_req     = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b1;
        #1;
        tests++;
        if (m_data_ok !== 4'b0001) begin fails++; $display("FAIL wr_dok: got %b expected 0001", m_data_ok); end
        tick();
        s_data_ok = 1'b0;
        $display("[TB] write req0 addr=00001000 wdata=12345678 after 4 stall cycles");
    endtask

    task automatic test_spurious();
        do_reset();
        s_data_ok = 1'b1;
        #1;
        tests++;
        if (m_data_ok !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL spur_idle: got dok=%b busy=%b expected 0000 0", m_data_ok, busy); end
        tick();
        set_master(1, 1'b0, 32'hABC0, 32'h0);
        m_req[1] = 1'b1;
        tick();
        #1;
        tests++;
        if (m_data_ok !== 4'b0000 || s_req !== 1'b1) begin fails++; $display("FAIL spur_addr: got dok=%b s_req=%b expected 0000 1", m_data_ok, s_req); end
        tick();
        #1;
        tests++;
        if (s_req !== 1'b1 || sel !== 2'd1) begin fails++; $display("FAIL spur_hold_addr: got s_req=%b sel=%0d expected 1 1", s_req, sel); end
        s_data_ok = 1'b0;
        s_addr_ok = 1'b1;
        tick();
        m_req     = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b1;
        #1;
        tests++;
        if (m_data_ok !== 4'b0010) begin fails++; $display("FAIL spur_real_dok: got %b expected 0010", m_data_ok); end
        tick();
        s_data_ok = 1'b0;
        $display("[TB] spurious data_ok ignored, req1 read completed");
    endtask

    task automatic test_master_drop();
        do_reset();
        set_master(3, 1'b0, 32'h3333, 32'h0);
        m_req[3] = 1'b1;
        tick();
        m_req = '0;
        #1;
        tests++;
        if (s_req !== 1'b1) begin fails++; $display("FAIL drop_sreq0: got %b expected 1", s_req); end
        tick();
        #1;
        tests++;
        if (s_req !== 1'b1 || sel !== 2'd3) begin fails++; $display("FAIL drop_sreq1: got s_req=%b sel=%0d expected 1 3", s_req, sel); end
        s_addr_ok = 1'b1;
        #1;
        tests++;
        if (m_addr_ok !== 4'b1000) begin fails++; $display("FAIL drop_aok: got %b expected 1000", m_addr_ok); end
        tick();
        s_addr_ok = 1'b0;
        s_data_ok = 1'b1;
        #1;
        tests++;
        if (m_data_ok !== 4'b1000) begin fails++; $display("FAIL drop_dok: got %b expected 1000", m_data_ok); end
        tick();
        s_data_ok = 1'b0;
        $display("[TB] req3 dropped in ADDR, transaction completed");
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_master(2, 1'b0, 32'h2222, 32'h0);
        m_req[2]  = 1'b1;
        s_addr_ok = 1'b1;
        tick();
        tick();
        m_req     = '0;
        s_addr_ok = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b1 || s_req !== 1'b0) begin fails++; $display("FAIL rmid_in_data: got busy=%b s_req=%b expected 1 0", busy, s_req); end
        #1;
        resetn    = 1'b0;
        s_data_ok = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || s_req !== 1'b0 || sel !== 2'd0) begin fails++; $display("FAIL rmid_async: got busy=%b s_req=%b sel=%0d expected 0 0 0", busy, s_req, sel); end
        tests++;
        if (m_data_ok !== 4'b0000 || m_addr_ok !== 4'b0000) begin fails++; $display("FAIL rmid_oks: got dok=%b aok=%b expected 0000 0000", m_data_ok, m_addr_ok); end
        tick();
        tick();
        resetn = 1'b1;
        #1;
        tests++;
        if (m_data_ok !== 4'b0000) begin fails++; $display("FAIL rmid_late_dok0: got %b expected 0000", m_data_ok); end
        tick();
        #1;
        tests++;
        if (m_data_ok !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL rmid_late_dok1: got dok=%b busy=%b expected 0000 0", m_data_ok, busy); end
        s_data_ok = 1'b0;
        $display("[TB] reset during DATA aborted transaction of req2");
    endtask

    task automatic test_random();
        int         ph;       // 0 idle, 1 address phase, 2 data phase
        int         last;
        int         msel;
        int         drop;
        int         wait_cnt[4];
        int         ngrants;
        logic [3:0] exp_aok;
        logic [3:0] exp_dok;
        do_reset();
        ph      = 0;
        last    = 3;
        msel    = 0;
        drop    = -1;
        ngrants = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 800; c++) begin
            if (drop >= 0) begin
                m_req[drop] = 1'b0;
                drop = -1;
            end
            for (int i = 0; i < 4; i++) begin
                if (!m_req[i] && ($urandom % 4 == 0)) begin
                    set_master(i, 1'($urandom), $urandom, $urandom);
                    m_req[i] = 1'b1;
                end
            end
            s_addr_ok = ($urandom % 3 == 0);
            s_data_ok = ($urandom % 3 == 0);
            s_rdata   = $urandom;
            #1;
            tests++;
            if (s_req !== (ph == 1) || busy !== (ph != 0)) begin fails++; $display("FAIL rnd_phase c%0d: got s_req=%b busy=%b model phase %0d", c, s_req, busy, ph); end
            if (ph != 0) begin
                tests++;
                if (sel !== 2'(msel)) begin fails++; $display("FAIL rnd_sel c%0d: got %0d expected %0d", c, sel, msel); end
            end
            if (ph == 1) begin
                tests++;
                if (s_addr !== m_addr[msel*AW +: AW] || s_wr !== m_wr[msel] || s_wdata !== m_wdata[msel*DW +: DW]) begin
                    fails++;
                    $display("FAIL rnd_mux c%0d: got addr=%h wr=%b wdata=%h expected %h %b %h", c, s_addr, s_wr, s_wdata,
                             m_addr[msel*AW +: AW], m_wr[msel], m_wdata[msel*DW +: DW]);
                end
            end
            exp_aok = (ph == 1 && s_addr_ok) ? (4'b0001 << msel) : 4'b0000;
            exp_dok = (ph == 2 && s_data_ok) ? (4'b0001 << msel) : 4'b0000;
            tests++;
            if (m_addr_ok !== exp_aok || m_data_ok !== exp_dok) begin fails++; $display("FAIL rnd_oks c%0d: got aok=%b dok=%b expected %b %b", c, m_addr_ok, m_data_ok, exp_aok, exp_dok); end
            if (exp_dok != 4'b0000) begin
                tests++;
                if (m_rdata !== s_rdata) begin fails++; $display("FAIL rnd_rdata c%0d: got %h expected %h", c, m_rdata, s_rdata); end
            end
            // Advance the model to what the next clock edge must produce.
            if (ph == 0 && m_req != 4'b0000) begin
                int w;
                w = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (w < 0 && m_req[(last + k) % 4]) w = (last + k) % 4;
                end
                for (int j = 0; j < 4; j++) begin
                    if (j != w && m_req[j]) begin
                        wait_cnt[j]++;
                        tests++;
                        if (wait_cnt[j] > 3) begin fails++; $display("FAIL rnd_fairness: requester %0d waited %0d transactions, limit 3", j, wait_cnt[j]); end
                    end
                end
                wait_cnt[w] = 0;
                last = w;
                msel = w;
                ph   = 1;
                ngrants++;
                $display("[TB] rnd grant %0d -> requester %0d wr=%b addr=%h", ngrants, w, m_wr[w], m_addr[w*AW +: AW]);
            end else if (ph == 1 && s_addr_ok) begin
                ph   = 2;
                drop = msel;
            end else if (ph == 2 && s_data_ok) begin
                ph = 0;
            end
            tick();
        end
        tests++;
        if (ngrants < 50) begin fails++; $display("FAIL rnd_activity: got %0d grants expected at least 50", ngrants); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_all_four();
        test_rr_13();
        test_write_stall();
        test_spurious();
        test_master_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
